// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a strobe-triggered, big-endian, byte-addressed data memory.
// One request at a time; sub-word stores are done as read-modify-write.
module mem_access_ctrl #(
    parameter int MEM_BYTES     = 64,
    parameter int STROBE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        op_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);
    localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, RD_STB, WR_STB, GAP, MERGE, DONE} state_t;

    typedef struct packed {
        logic        op_write;
        logic [1:0]  size;
        logic        sign_ext;
        logic [1:0]  lane;
        logic [15:0] wdata;
    } req_t;

    state_t        state;
    req_t          cur;
    logic [CW-1:0] cnt;
    logic          wrote;
    logic [31:0]   rd_word;

    logic          illegal;
    logic [7:0]    lbyte;
    logic [15:0]   lhalf;
    logic [31:0]   load_ext;
    logic [31:0]   merged;

    always_comb begin
        illegal = (size == 2'b11) || (addr >= 32'(MEM_BYTES)) ||
                  (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    end

    // Lane select and extension for loads, lane replacement for sub-word stores.
    always_comb begin
        lbyte    = 8'h00;
        lhalf    = cur.lane[1] ? rd_word[15:0] : rd_word[31:16];
        load_ext = rd_word;
        merged   = rd_word;
        case (cur.lane)
            2'd0:    lbyte = rd_word[31:24];
            2'd1:    lbyte = rd_word[23:16];
            2'd2:    lbyte = rd_word[15:8];
            default: lbyte = rd_word[7:0];
        endcase
        case (cur.size)
            2'b00:   load_ext = {{24{cur.sign_ext & lbyte[7]}}, lbyte};
            2'b01:   load_ext = {{16{cur.sign_ext & lhalf[15]}}, lhalf};
            default: load_ext = rd_word;
        endcase
        if (cur.size == 2'b00) begin
            case (cur.lane)
                2'd0:    merged[31:24] = cur.wdata[7:0];
                2'd1:    merged[23:16] = cur.wdata[7:0];
                2'd2:    merged[15:8]  = cur.wdata[7:0];
                default: merged[7:0]   = cur.wdata[7:0];
            endcase
        end else if (cur.lane[1]) begin
            merged[15:0] = cur.wdata;
        end else begin
            merged[31:16] = cur.wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cur            <= '0;
            cnt            <= '0;
            wrote          <= 1'b0;
            rd_word        <= '0;
            ready          <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
            rdata          <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    cur   <= '{op_write, size, sign_ext, addr[1:0], wdata[15:0]};
                    ready <= 1'b0;
                    wrote <= 1'b0;
                    if (illegal) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        err         <= 1'b0;
                        mem_address <= {addr[31:2], 2'b00};
                        if (op_write && size == 2'b10) mem_write_data <= wdata;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    cnt <= CW'(STROBE_CYCLES - 1);
                    if (cur.op_write && cur.size == 2'b10) begin
                        mem_write <= 1'b1;
                        wrote     <= 1'b1;
                        state     <= WR_STB;
                    end else begin
                        mem_read <= 1'b1;
                        state    <= RD_STB;
                    end
                end
                RD_STB: if (cnt == '0) begin
                    mem_read <= 1'b0;
                    rd_word  <= mem_read_data;
                    state    <= GAP;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                WR_STB: if (cnt == '0) begin
                    mem_write <= 1'b0;
                    state     <= GAP;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                // A store that has not written yet is mid-RMW: merge, then write.
                GAP: if (cur.op_write && !wrote) begin
                    mem_write_data <= merged;
                    state          <= MERGE;
                end else begin
                    if (!cur.op_write) rdata <= load_ext;
                    done  <= 1'b1;
                    state <= DONE;
                end
                MERGE: begin
                    cnt       <= CW'(STROBE_CYCLES - 1);
                    mem_write <= 1'b1;
                    wrote     <= 1'b1;
                    state     <= WR_STB;
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a strobe-triggered 64-byte memory model.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req = 1'b0, op_write = 1'b0, sign_ext = 1'b0;
    logic [1:0]  size = 2'b10;
    logic [31:0] addr = '0, wdata = '0;
    logic        ready, done, err, mem_read, mem_write;
    logic [31:0] rdata, mem_address, mem_write_data;
    logic [31:0] mem_read_data = '0;

    int tests = 0, fails = 0;
    int rd_cnt = 0, wr_cnt = 0, overlap = 0;
    logic [31:0] last_rd_addr = '0, last_wr_addr = '0;
    logic [31:0] mem [16];

    mem_access_ctrl #(.MEM_BYTES(64), .STROBE_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .req(req), .op_write(op_write), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .ready(ready), .done(done),
        .rdata(rdata), .err(err), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory reinitialises with the controller reset.
    always @(posedge mem_write or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h01010101 * i;
            mem[1] <= 32'hFC200004;
            mem[4] <= 32'h10111213;
        end else begin
            mem[mem_address[5:2]] <= mem_write_data;
            last_wr_addr          <= mem_address;
            wr_cnt                <= wr_cnt + 1;
        end
    end

    always @(posedge mem_read) begin
        mem_read_data <= mem[mem_address[5:2]];
        last_rd_addr  <= mem_address;
        rd_cnt        <= rd_cnt + 1;
    end

    always @(negedge clk) if (mem_read && mem_write) overlap <= overlap + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request, scrambles inputs after accept, returns cycles from accept to done.
    task automatic do_req(input logic ow, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin @(negedge clk); n++; end
        op_write = ow; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; addr = $urandom; wdata = $urandom; size = 2'($urandom); sign_ext = ~sx;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!done && lat < 40);
    endtask

    int lat, r0, w0, n, dones;
    logic [31:0] last_rdata;
    logic        v_ow [3];
    logic [31:0] v_a  [3];

    initial begin
        reset = 1'b1;
        #2 reset = 1'b0;
        #10;
        chk("rst_ready", 32'(ready), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_strobes", {30'd0, mem_read, mem_write}, 0);
        chk("rst_maddr", mem_address, 0);
        chk("rst_wdata", mem_write_data, 0);
        @(posedge clk); #3 reset = 1'b1;

        // Word load
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(0, 2'b10, 0, 32'd4, 0, lat);
        chk("lw4_lat", lat, 4);
        chk("lw4_rdata", rdata, 32'hFC200004);
        chk("lw4_err", 32'(err), 0);
        chk("lw4_rd_pulses", rd_cnt - r0, 1);
        chk("lw4_wr_pulses", wr_cnt - w0, 0);
        chk("lw4_maddr", last_rd_addr, 4);

        // Sub-word loads
        do_req(0, 2'b00, 1, 32'd4, 0, lat);
        chk("lb4", rdata, 32'hFFFFFFFC);
        do_req(0, 2'b00, 0, 32'd4, 0, lat);
        chk("lbu4", rdata, 32'h000000FC);
        do_req(0, 2'b01, 1, 32'd4, 0, lat);
        chk("lh4", rdata, 32'hFFFFFC20);
        do_req(0, 2'b01, 0, 32'd6, 0, lat);
        chk("lhu6", rdata, 32'h00000004);
        do_req(0, 2'b00, 0, 32'd7, 0, lat);
        chk("lbu7", rdata, 32'h00000004);

        // Byte and half stores (read-modify-write)
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(1, 2'b00, 0, 32'd17, 32'h000000AB, lat);
        chk("sb17_lat", lat, 7);
        chk("sb17_rd_pulses", rd_cnt - r0, 1);
        chk("sb17_wr_pulses", wr_cnt - w0, 1);
        chk("sb17_waddr", last_wr_addr, 16);
        chk("sb17_wdata", mem_write_data, 32'h10AB1213);
        do_req(0, 2'b10, 0, 32'd16, 0, lat);
        chk("lw16_after_sb", rdata, 32'h10AB1213);
        do_req(1, 2'b01, 0, 32'd18, 32'h12345566, lat);
        chk("sh18_lat", lat, 7);
        do_req(0, 2'b10, 0, 32'd16, 0, lat);
        chk("lw16_after_sh", rdata, 32'h10AB5566);

        // Illegal requests
        last_rdata = 32'h10AB5566;
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(1, 2'b10, 0, 32'd6, 32'hFFFFFFFF, lat);
        chk("sw6_lat", lat, 1);
        chk("sw6_err", 32'(err), 1);
        do_req(0, 2'b10, 0, 32'd64, 0, lat);
        chk("lw64_lat", lat, 1);
        chk("lw64_err", 32'(err), 1);
        do_req(0, 2'b11, 0, 32'd0, 0, lat);
        chk("size11_err", 32'(err), 1);
        do_req(0, 2'b01, 0, 32'd5, 0, lat);
        chk("lh5_err", 32'(err), 1);
        chk("err_no_pulses", (rd_cnt - r0) + (wr_cnt - w0), 0);
        chk("err_rdata_kept", rdata, last_rdata);
        do_req(0, 2'b10, 0, 32'd60, 0, lat);
        chk("lw60_err", 32'(err), 0);
        chk("lw60_rdata", rdata, 32'h0F0F0F0F);

        // Back-to-back with req held high
        v_ow = '{1'b0, 1'b1, 1'b0};
        v_a  = '{32'd8, 32'd12, 32'd12};
        r0 = rd_cnt; w0 = wr_cnt; dones = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            op_write = v_ow[i]; size = 2'b10; addr = v_a[i]; wdata = 32'hDEADBEEF; req = 1'b1;
            n = 0;
            while (!ready && n < 20) begin @(negedge clk); n++; end
            @(posedge clk); #1;
            if (i == 2) req = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (!done && n < 40);
            if (done) dones++;
        end
        chk("b2b_dones", dones, 3);
        chk("b2b_rd_pulses", rd_cnt - r0, 2);
        chk("b2b_wr_pulses", wr_cnt - w0, 1);
        chk("b2b_rdata", rdata, 32'hDEADBEEF);

        // Reset during the write strobe of a byte store
        @(negedge clk);
        op_write = 1'b1; size = 2'b00; addr = 32'd17; wdata = 32'h55; req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        n = 0;
        while (!mem_write && n < 20) begin @(negedge clk); n++; end
        chk("rmw_reached_wr", 32'(mem_write), 1);
        #1 reset = 1'b0;
        #1;
        chk("rstmid_mem_write", 32'(mem_write), 0);
        chk("rstmid_mem_read", 32'(mem_read), 0);
        chk("rstmid_ready", 32'(ready), 1);
        chk("rstmid_rdata", rdata, 0);
        chk("rstmid_maddr", mem_address, 0);
        @(posedge clk); #3 reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (done) dones++; end
        chk("rstmid_no_done", dones, 0);
        chk("rstmid_ready_after", 32'(ready), 1);
        do_req(0, 2'b10, 0, 32'd16, 0, lat);
        chk("lw16_after_reset", rdata, 32'h10111213);

        chk("strobe_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
